// File: rtl/downcounter_pkg.sv
// rtl/downcounter_pkg.sv - shared state encoding and default width for the down counter
package downcounter_pkg;

    localparam int DC_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } dc_state_t;

endpackage

// File: rtl/downcounter.sv
// rtl/downcounter.sv - loadable down counter with terminal-count flag and borrow pulse
// Optional feature: DOWNCOUNTER_AUTORELOAD_EN (periodic reload from last loaded value)
module downcounter
    import downcounter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             decr,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             done,
    output logic             borrow
);

    dc_state_t        state;
    dc_state_t        state_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] wrap;
    logic             borrow_next;

`ifdef DOWNCOUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] rl;
    logic [WIDTH-1:0] rl_next;

    assign wrap = rl;
`else
    assign wrap = {WIDTH{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state  <= S_IDLE;
            q      <= '0;
            done   <= 1'b0;
            borrow <= 1'b0;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
            rl     <= '0;
`endif
        end else begin
            state  <= state_next;
            q      <= q_next;
            done   <= (state_next == S_DONE);
            borrow <= borrow_next;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
            rl     <= rl_next;
`endif
        end
    end

    always_comb begin
        state_next  = state;
        q_next      = q;
        borrow_next = 1'b0;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
        rl_next     = rl;
`endif
        if (load) begin
            q_next     = d;
            state_next = (d == '0) ? S_DONE : S_RUN;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
            rl_next    = d;
`endif
        end else if (decr) begin
            case (state)
                S_RUN: begin
                    q_next = q - WIDTH'(1);
                    if (q == WIDTH'(1)) begin
                        state_next = S_DONE;
                    end
                end
                // Expiry already signalled; a further decrement borrows and restarts the count.
                S_DONE: begin
                    borrow_next = 1'b1;
                    q_next      = wrap;
                    state_next  = (wrap == '0) ? S_DONE : S_RUN;
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_comb begin
        zero = (q == '0);
    end

endmodule

// File: tb/tb_downcounter.sv
// tb/tb_downcounter.sv - self-checking bench for downcounter against a behavioural timer model
module tb_downcounter;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] d;
    logic       load;
    logic       decr;
    logic [3:0] q;
    logic       zero;
    logic       done;
    logic       borrow;

    int checks = 0;
    int errors = 0;

    // Reference: a timer that has been armed (active), its remaining count,
    // whether it has expired, and the last value loaded.
    int m_q      = 0;
    int m_rl     = 0;
    bit m_active = 0;
    bit m_done   = 0;
    bit m_borrow = 0;

    logic [6:0] got;
    logic [6:0] exp;

    downcounter #(.WIDTH(4)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .d       (d),
        .load    (load),
        .decr    (decr),
        .q       (q),
        .zero    (zero),
        .done    (done),
        .borrow  (borrow)
    );

    always #5 clk = ~clk;

    function automatic int wrap_value();
`ifdef DOWNCOUNTER_AUTORELOAD_EN
        return m_rl;
`else
        return 15;
`endif
    endfunction

    task automatic drive(input bit c_n, input bit ld, input bit dc, input int dv);
        clear_n = c_n;
        load    = ld;
        decr    = dc;
        d       = 4'(dv);
        @(posedge clk);
        m_borrow = 0;
        if (!c_n) begin
            m_q = 0; m_rl = 0; m_active = 0; m_done = 0;
        end else if (ld) begin
            m_q = dv % 16; m_rl = dv % 16; m_active = 1; m_done = (m_q == 0);
        end else if (dc && m_active) begin
            if (m_done) begin
                m_borrow = 1;
                m_q = wrap_value();
            end else begin
                m_q = (m_q + 15) % 16;
            end
            m_done = (m_q == 0);
        end
        #1;
        got = {q, done, borrow, zero};
        exp = {4'(m_q), m_done, m_borrow, (m_q == 0)};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 9);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset model: got %h expected %h", got, exp); end
        end
        checks++;
        if ({q, done, borrow} !== 6'b0) begin errors++; $display("FAIL reset_const: got q=%0d done=%b borrow=%b expected 0/0/0", q, done, borrow); end
    endtask

    task automatic test_load_count();
        drive(1, 1, 0, 3);
        checks++;
        if (q !== 4'd3 || done !== 1'b0) begin errors++; $display("FAIL load3: got q=%0d done=%b expected 3/0", q, done); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL count model: got %h expected %h", got, exp); end
        end
        checks++;
        if (q !== 4'd0 || done !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL count_end: got q=%0d done=%b zero=%b expected 0/1/1", q, done, zero); end
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, 0);
        checks++;
        if (q !== 4'(wrap_value()) || borrow !== 1'b1) begin errors++; $display("FAIL wrap: got q=%0d borrow=%b expected %0d/1", q, borrow, wrap_value()); end
        drive(1, 0, 0, 0);
        checks++;
        if (got !== exp || borrow !== 1'b0) begin errors++; $display("FAIL wrap_pulse: got %h expected %h", got, exp); end
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 7);
        drive(1, 1, 1, 5);
        checks++;
        if (q !== 4'd5 || borrow !== 1'b0) begin errors++; $display("FAIL load_wins: got q=%0d borrow=%b expected 5/0", q, borrow); end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0);
            checks++;
            if (got !== exp || q !== 4'd0) begin errors++; $display("FAIL idle_decr: got %h expected %h", got, exp); end
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 1, 0, 8);
        drive(1, 0, 1, 0);
        drive(1, 0, 1, 0);
        checks++;
        if (q !== 4'd6) begin errors++; $display("FAIL mid_count: got q=%0d expected 6", q); end
        drive(0, 0, 1, 0);
        checks++;
        if (q !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset: got q=%0d done=%b expected 0/0", q, done); end
        drive(1, 0, 1, 0);
        checks++;
        if (got !== exp || borrow !== 1'b0) begin errors++; $display("FAIL post_reset_decr: got %h expected %h", got, exp); end
    endtask

    task automatic test_zero_load();
        drive(1, 1, 0, 0);
        checks++;
        if (q !== 4'd0 || zero !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL zero_load: got q=%0d zero=%b done=%b expected 0/1/1", q, zero, done); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 0);
            checks++;
            if (got !== exp || borrow !== 1'b1) begin errors++; $display("FAIL zero_decr: got %h expected %h", got, exp); end
            drive(1, 1, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 4) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    initial begin
        clear_n = 1'b0; load = 1'b0; decr = 1'b0; d = '0;
        test_reset();
        test_load_count();
        test_wrap();
        test_priority();
        test_mid_reset();
        test_zero_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
